bus_fabric: RTL and testbench
=============================

# bus_fabric

Parametrised single-initiator bus interconnect that sits between `cpu` and the memory-mapped targets (code ROM, `bsmem`, `uart`, video engine). It replaces the fixed 3-bit address decode and registered read mux of the SoC top with a configurable target count and region map. It adds per-target ready/wait-state handshaking, a bounded wait timeout, and error signalling with a captured error address for unmapped or hung accesses.

## Interface
- `NUM_TGT`, default 4: number of target ports, 1..8.
- `SEL_BITS`, default 3: number of top address bits decoded; region select is `m_addr_i[31:32-SEL_BITS]`.
- `TGT_SEL`, default {3'b100,3'b010,3'b001,3'b000}: packed `NUM_TGT*SEL_BITS`; slice k is the region value of target k.
- `TIMEOUT`, default 255: maximum wait cycles before error completion; 0 disables the timeout.

Ports:
- `clk_i` in 1: single clock; all state is updated on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `m_enable_i` in 1: initiator request valid.
- `m_wstrb_i` in 4: byte write strobes; 0 means read.
- `m_addr_i` in 32: request address.
- `m_wvalue_i` in 32: write data.
- `m_rvalue_o` out 32: read data, one cycle after completion.
- `m_ready_o` out 1: request completes this cycle.
- `m_err_o` out 1: completion is an error; valid only with `m_ready_o`.
- `t_enable_o` out NUM_TGT: one-hot target request.
- `t_wstrb_o` out 4, `t_addr_o` out 32, `t_wvalue_o` out 32: broadcast copies of the `m_*` request signals.
- `t_rvalue_i` in NUM_TGT*32: target read data; slice k belongs to target k.
- `t_ready_i` in NUM_TGT: target accepts or completes this cycle.
- `err_valid_o` out 1: an error has been captured.
- `err_addr_o` out 32: address of the first captured error.
- `err_clr_i` in 1: clears `err_valid_o`.

## Operation
- Decode: target k hits when the region bits equal `TGT_SEL[k]`. If several targets match, the lowest index wins. No match means unmapped.
- States:
  - IDLE: no request in flight.
  - WAIT: a request has been issued and its target has not yet completed it.
- IDLE, `m_enable_i`=0: all `t_enable_o`=0, `m_ready_o`=0.
- IDLE, `m_enable_i`=1, hit k: `t_enable_o[k]`=1 combinationally.
  - `t_ready_i[k]`=1: `m_ready_o`=1, stay in IDLE.
  - Otherwise: latch k and enter WAIT with the wait counter set to 1.
- IDLE, `m_enable_i`=1, unmapped: `m_ready_o`=1 and `m_err_o`=1 in the same cycle, error captured, no `t_enable_o` asserted.
- WAIT:
  - `t_enable_o[k]` held at 1.
  - The initiator must hold its `m_*` request stable; the fabric does not re-decode.
  - `t_ready_i[k]`=1: normal completion, go to IDLE.
  - Counter == `TIMEOUT` and ready low: error completion (`m_ready_o`=1, `m_err_o`=1, `t_enable_o`=0 this cycle), error captured, go to IDLE.
  - Otherwise increment the counter.
  - Ready and timeout in the same cycle: ready wins.
- Read mux: on every completion, register the selected index, or a none marker for an error completion. Next cycle, `m_rvalue_o` = `t_rvalue_i[sel_q]`, or 0 for none. `sel_q` holds until the next completion.
- Error capture: on an error, if `err_valid_o`=0, load `err_addr_o`=`m_addr_i` and set `err_valid_o`. Later errors do not overwrite.
  - `err_clr_i` clears `err_valid_o`; `err_addr_o` keeps its value.
  - Clear and new error in the same cycle: the new error is captured (set wins).
- `m_err_o` is combinational and is 0 whenever `m_ready_o`=0.

## Timing
- Zero-wait target: request and completion in cycle N, read data in N+1. This matches the existing one-cycle synchronous read latency.
- Wait states: completion in the first cycle with `t_ready_i[k]`=1. The earliest next request is the following cycle (back-to-back accesses are allowed).
- Timeout: a request issued in IDLE at cycle N with ready never asserted completes with an error at cycle N+`TIMEOUT`.
- Counter width: `$clog2(TIMEOUT+1)`; the counter never wraps.
- Reset values:
  - State IDLE, counter 0, `sel_q` = none.
  - `m_rvalue_o`=0, `m_ready_o`=0, `m_err_o`=0, `t_enable_o`=0.
  - `err_valid_o`=0, `err_addr_o`=0.
- While `rst_i`=1, `t_enable_o`, `m_ready_o` and `m_err_o` are forced to 0.
- Reset in WAIT abandons the transaction: no completion and no error capture.

## Test plan
- Read of 0x2000_0010, target 1 ready the same cycle, `t_rvalue_i[1]`=0xDEADBEEF -> `m_ready_o`=1 that cycle, `m_rvalue_o`=0xDEADBEEF next cycle, `m_err_o`=0.
- Write of 0x4000_0000, wstrb=4'b0001, target 2 ready after 3 wait cycles -> `t_enable_o`=4'b0100 for 4 cycles, `m_ready_o` only in the 4th, `t_wstrb_o`=4'b0001 throughout.
- Access to 0x6000_0000 (unmapped) -> same-cycle `m_ready_o`=`m_err_o`=1, `err_addr_o`=0x6000_0000, `m_rvalue_o`=0 next cycle.
- `TIMEOUT`=4, target 3 never ready -> error completion exactly 4 cycles after issue, `t_enable_o`=0 in that cycle; a second error does not change `err_addr_o`; `err_clr_i` pulsed in the same cycle as a third error (to 0xE000_0000, unmapped) -> `err_valid_o` stays 1 with `err_addr_o`=0xE000_0000.
- `rst_i` asserted during WAIT on target 0 -> next cycle all outputs at reset values, no error captured; a new request is then accepted normally.

Source files
------------

// File: rtl/bus_fabric.sv
// Single-initiator bus interconnect: region decode, wait-state
// handshake, bounded timeout and first-error address capture.
module bus_fabric #(
  parameter int NUM_TGT = 4,
  parameter int SEL_BITS = 3,
  parameter logic [NUM_TGT*SEL_BITS-1:0] TGT_SEL =
    {3'b100, 3'b010, 3'b001, 3'b000},
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m_enable_i,
  input  logic [3:0]            m_wstrb_i,
  input  logic [31:0]           m_addr_i,
  input  logic [31:0]           m_wvalue_i,
  output logic [31:0]           m_rvalue_o,
  output logic                  m_ready_o,
  output logic                  m_err_o,
  output logic [NUM_TGT-1:0]    t_enable_o,
  output logic [3:0]            t_wstrb_o,
  output logic [31:0]           t_addr_o,
  output logic [31:0]           t_wvalue_o,
  input  logic [NUM_TGT*32-1:0] t_rvalue_i,
  input  logic [NUM_TGT-1:0]    t_ready_i,
  output logic                  err_valid_o,
  output logic [31:0]           err_addr_o,
  input  logic                  err_clr_i
);

  localparam int IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] tgt_q;
  logic [IW-1:0] sel_q;
  logic          sel_none_q;
  logic          err_valid_q;
  logic [31:0]   err_addr_q;

  logic [SEL_BITS-1:0] region;
  logic                hit;
  logic [IW-1:0]       hit_idx;
  logic [IW-1:0]       cur_idx;
  logic [NUM_TGT-1:0]  onehot;
  logic [31:0]         rv [NUM_TGT];
  logic                in_wait;
  logic                active;
  logic                tgt_rdy;
  logic                tmo_hit;
  logic                unmapped;
  logic                ok_done;
  logic                err_done;

  assign region = m_addr_i[31:32-SEL_BITS];

  // Region decode, lowest matching target index wins
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int k = NUM_TGT - 1; k >= 0; k--) begin
      if (region == TGT_SEL[k*SEL_BITS +: SEL_BITS]) begin
        hit = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  for (genvar g = 0; g < NUM_TGT; g++) begin : g_rv
    assign rv[g] = t_rvalue_i[g*32 +: 32];
  end

  assign in_wait  = (state_q == S_WAIT);
  assign cur_idx  = in_wait ? tgt_q : hit_idx;
  assign tgt_rdy  = t_ready_i[cur_idx];
  assign tmo_hit  = TMO_EN && in_wait && (cnt_q == TMO);
  assign unmapped = !in_wait && m_enable_i && !hit;
  assign active   = !rst_i && (in_wait || (m_enable_i && hit));
  assign ok_done  = active && tgt_rdy;
  assign err_done = !rst_i && (unmapped || (tmo_hit && !tgt_rdy));

  assign m_ready_o = ok_done || err_done;
  assign m_err_o   = err_done;

  // One-hot target request, dropped in the timeout cycle
  always_comb begin
    onehot = '0;
    onehot[cur_idx] = 1'b1;
    t_enable_o = '0;
    if (active && !(tmo_hit && !tgt_rdy))
      t_enable_o = onehot;
  end

  assign t_wstrb_o  = m_wstrb_i;
  assign t_addr_o   = m_addr_i;
  assign t_wvalue_o = m_wvalue_i;

  assign m_rvalue_o  = sel_none_q ? 32'h0 : rv[sel_q];
  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;

  // Request FSM with saturating wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (m_enable_i && hit && !tgt_rdy) begin
            state_q <= S_WAIT;
            tgt_q   <= hit_idx;
            cnt_q   <= CW'(1);
          end
        end
        S_WAIT: begin
          if (tgt_rdy || tmo_hit) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (TMO_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read-mux select captured at every completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q      <= '0;
      sel_none_q <= 1'b1;
    end else if (m_ready_o) begin
      sel_q      <= cur_idx;
      sel_none_q <= m_err_o;
    end
  end

  // First-error capture; a new error beats a same-cycle clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (m_err_o && (!err_valid_q || err_clr_i)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= m_addr_i;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: driver pushes expected
// completions, monitor pops and checks them.
module tb_bus_fabric;

  localparam int TMO = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         m_enable_i;
  logic [3:0]   m_wstrb_i;
  logic [31:0]  m_addr_i;
  logic [31:0]  m_wvalue_i;
  logic [31:0]  m_rvalue_o;
  logic         m_ready_o;
  logic         m_err_o;
  logic [3:0]   t_enable_o;
  logic [3:0]   t_wstrb_o;
  logic [31:0]  t_addr_o;
  logic [31:0]  t_wvalue_o;
  logic [127:0] t_rvalue_i;
  logic [3:0]   t_ready_i;
  logic         err_valid_o;
  logic [31:0]  err_addr_o;
  logic         err_clr_i;

  bus_fabric #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_enable_i(m_enable_i), .m_wstrb_i(m_wstrb_i),
    .m_addr_i(m_addr_i), .m_wvalue_i(m_wvalue_i),
    .m_rvalue_o(m_rvalue_o), .m_ready_o(m_ready_o),
    .m_err_o(m_err_o), .t_enable_o(t_enable_o),
    .t_wstrb_o(t_wstrb_o), .t_addr_o(t_addr_o),
    .t_wvalue_o(t_wvalue_o), .t_rvalue_i(t_rvalue_i),
    .t_ready_i(t_ready_i), .err_valid_o(err_valid_o),
    .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          err;
    int          idx;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // region value of each target, address bits [31:29]
  int unsigned region_map [4] = '{0, 1, 2, 4};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got %h want %h", name, act, exp);
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if (int'(a >> 29) == region_map[k]) return k;
    return -1;
  endfunction

  task automatic rand_rdata();
    t_rvalue_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      m_enable_i = 1'b0;
      t_ready_i  = 4'($urandom);
      err_clr_i  = clr;
      rand_rdata();
      @(negedge clk_i);
      chk("idle_ready", 32'(m_ready_o), 32'd0);
      chk("idle_enable", 32'(t_enable_o), 32'd0);
      @(posedge clk_i); #1;
    end
    err_clr_i = 1'b0;
  endtask

  // lat: cycle offset at which the target raises ready, <0 = never
  task automatic run_xact(input logic [31:0] addr, input logic [3:0] ws,
                          input int lat, input bit clr_done);
    int tgt;
    int done;
    bit err;
    logic [3:0] oh;
    logic [31:0] wv;
    tgt = model_decode(addr);
    if (tgt < 0) begin
      done = 0; err = 1'b1;
    end else if (lat >= 0 && lat <= TMO) begin
      done = lat; err = 1'b0;
    end else begin
      done = TMO; err = 1'b1;
    end
    exp_q.push_back('{err: err, idx: (tgt < 0) ? 0 : tgt, addr: addr});
    oh = (tgt < 0) ? 4'd0 : 4'(1 << tgt);
    wv = $urandom;
    for (int c = 0; c <= done; c++) begin
      m_enable_i = 1'b1;
      m_addr_i   = addr;
      m_wstrb_i  = ws;
      m_wvalue_i = wv;
      t_ready_i  = 4'($urandom);
      if (tgt >= 0) t_ready_i[tgt] = (c == lat);
      err_clr_i  = clr_done && (c == done);
      rand_rdata();
      @(negedge clk_i);
      chk("t_enable", 32'(t_enable_o),
          32'((err && c == done) ? 4'd0 : oh));
      chk("t_wstrb", 32'(t_wstrb_o), 32'(ws));
      chk("t_addr", t_addr_o, addr);
      chk("m_ready", 32'(m_ready_o), 32'(c == done));
      @(posedge clk_i); #1;
    end
    m_enable_i = 1'b0;
    err_clr_i  = 1'b0;
  endtask

  // Monitor with error-register reference model
  bit          mv = 1'b0;
  logic [31:0] ma = '0;
  bit          rd_pend = 1'b0;
  bit          rd_err;
  int          rd_idx;

  always @(negedge clk_i) begin
    exp_t e;
    bit cerr;
    if (rst_i) begin
      mv = 1'b0; ma = '0; rd_pend = 1'b0;
    end else begin
      chk("err_valid", 32'(err_valid_o), 32'(mv));
      chk("err_addr", err_addr_o, ma);
      if (rd_pend)
        chk("m_rvalue", m_rvalue_o,
            rd_err ? 32'h0 : t_rvalue_i[rd_idx*32 +: 32]);
      rd_pend = 1'b0;
      cerr = 1'b0;
      if (m_ready_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'(m_ready_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("m_err", 32'(m_err_o), 32'(e.err));
          rd_pend = 1'b1;
          rd_err  = e.err;
          rd_idx  = e.idx;
          cerr    = e.err;
        end
      end else if (m_err_o) begin
        chk("m_err_no_ready", 32'(m_err_o), 32'd0);
      end
      if (cerr && (!mv || err_clr_i)) begin
        mv = 1'b1; ma = e.addr;
      end else if (err_clr_i) begin
        mv = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; m_enable_i = 1'b0; m_wstrb_i = '0;
    m_addr_i = '0; m_wvalue_i = '0; t_ready_i = '0;
    err_clr_i = 1'b0; t_rvalue_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_rvalue", m_rvalue_o, 32'h0);
    chk("rst_ready", 32'(m_ready_o), 32'd0);
    chk("rst_err", 32'(m_err_o), 32'd0);
    chk("rst_enable", 32'(t_enable_o), 32'd0);
    chk("rst_err_valid", 32'(err_valid_o), 32'd0);
    chk("rst_err_addr", err_addr_o, 32'h0);
    @(posedge clk_i); #1;

    run_xact(32'h2000_0010, 4'b0000, 0, 1'b0);
    run_xact(32'h4000_0000, 4'b0001, 3, 1'b0);
    run_xact(32'h6000_0000, 4'b0000, 0, 1'b0);
    idle(1, 1'b0);
    chk("unmapped_addr", err_addr_o, 32'h6000_0000);
    idle(1, 1'b1);
    run_xact(32'h8000_0000, 4'b0000, -1, 1'b0);
    idle(1, 1'b0);
    chk("tmo_addr", err_addr_o, 32'h8000_0000);
    run_xact(32'h6000_0004, 4'b0000, 0, 1'b0);
    idle(1, 1'b0);
    chk("no_overwrite", err_addr_o, 32'h8000_0000);
    run_xact(32'hE000_0000, 4'b0000, 0, 1'b1);
    idle(1, 1'b0);
    chk("clr_set_valid", 32'(err_valid_o), 32'd1);
    chk("clr_set_addr", err_addr_o, 32'hE000_0000);
    run_xact(32'h8000_0040, 4'b1111, 4, 1'b0);

    m_enable_i = 1'b1; m_addr_i = 32'h0000_0100;
    m_wstrb_i = 4'b0000; t_ready_i = 4'b0000;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_wait_ready", 32'(m_ready_o), 32'd0);
    chk("rst_wait_enable", 32'(t_enable_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; m_enable_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_valid", 32'(err_valid_o), 32'd0);
    chk("post_rst_rvalue", m_rvalue_o, 32'h0);
    chk("post_rst_enable", 32'(t_enable_o), 32'd0);
    @(posedge clk_i); #1;
    run_xact(32'h0000_0200, 4'b0000, 1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom;
      run_xact(a, 4'($urandom), $urandom_range(0, 6),
               ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) == 0)
        idle($urandom_range(1, 2), ($urandom_range(0, 3) == 0));
    end
    idle(2, 1'b0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
